pico_alu: RTL and testbench
===========================

PICO_ALU -- requirements
Module: pico_alu

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the destination register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request: launch operation, sampled at rising clk.
REQ-006 op  input  3  alu_op_t opcode.
REQ-007 a  input  BUS_WIDTH  first operand (register file rd_data).
REQ-008 b  input  BUS_WIDTH  second operand (register file rs_data).
REQ-009 imm  input  BUS_WIDTH  immediate operand.
REQ-010 use_imm  input  1  when 1, imm replaces b.
REQ-011 dest_addr  input  ADDR_WIDTH  destination register address.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 we  output  1  register file write enable; identical to done.
REQ-015 wr_addr  output  ADDR_WIDTH  captured dest_addr, driven to register file.
REQ-016 result  output  BUS_WIDTH  registered result (register file wr_data).

Function
REQ-017 Operands, op and dest_addr SHALL be captured on the rising edge where start=1 and state=IDLE; start in any other state SHALL be ignored.
REQ-018 Opcodes SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, MUL=5 (low BUS_WIDTH bits of unsigned product), MULH=6 (high BUS_WIDTH bits), PASS=7 (second operand).
REQ-019 ADD/SUB SHALL wrap modulo 2^BUS_WIDTH; no carry/overflow output.
REQ-020 FSM states SHALL be IDLE, MUL_RUN, WB; IDLE->WB for ops 0-4,7; IDLE->MUL_RUN for ops 5,6; MUL_RUN->WB after exactly BUS_WIDTH cycles; WB->IDLE unconditionally.
REQ-021 MUL_RUN SHALL perform one shift-add step per cycle on a 2*BUS_WIDTH-bit accumulator, counted by a down-counter loaded with BUS_WIDTH-1.
REQ-022 done and we SHALL be high exactly during WB; single-cycle op latency SHALL be 1 cycle (start edge k -> done cycle k+1); MUL/MULH latency SHALL be BUS_WIDTH+1 cycles.
REQ-023 result and wr_addr SHALL be updated on entry to WB and held stable until the next entry to WB.
REQ-024 Writes to dest_addr 0 SHALL still assert we; the register file discards them.
REQ-025 start asserted in WB SHALL be ignored; back-to-back ops therefore issue no faster than every 2 cycles.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, accumulator 0, result 0, wr_addr 0, busy 0, done 0, we 0 immediately and independent of clk.
REQ-027 reset asserted mid-MUL_RUN SHALL abort the operation with no write pulse; the first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-028 Macro PICO_ALU_FLAGS_EN, when defined, SHALL add outputs zero (1) and neg (1), registered on entry to WB from result==0 and result[BUS_WIDTH-1], reset to 0 and held like result.
REQ-029 Without PICO_ALU_FLAGS_EN the zero and neg ports and their registers SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-030 Package pico_pkg SHALL hold alu_op_t (3-bit enum), alu_state_t (IDLE, MUL_RUN, WB) and default BUS_WIDTH/ADDR_WIDTH constants.
REQ-031 The shift-add multiplier datapath (accumulator, counter) SHALL be a sub-module pico_mul_seq with start/done handshake; the FSM and simple ops stay in pico_alu.

Verification (BUS_WIDTH=8)
REQ-032 ADD a=0xF0 b=0x20 start 1 cycle -> next cycle done=we=1, result=0x10, busy=1 for 1 cycle.
REQ-033 SUB use_imm=1 a=0x05 imm=0x07 dest_addr=3 -> result=0xFE, wr_addr=3, done one cycle.
REQ-034 MUL a=200 b=3 -> busy 9 cycles, done in cycle 9 after start edge, result=0x58; MULH same operands -> result=0x02.
REQ-035 start held high continuously with ADD ops -> done every 2nd cycle; start during MUL_RUN ignored, no extra done.
REQ-036 reset pulsed 4 cycles into MUL 13*11 -> all outputs 0 immediately, no done; re-issued MUL 13*11 -> result=0x8F.
REQ-037 With PICO_ALU_FLAGS_EN: XOR a=b=0x5A -> result=0x00, zero=1, neg=0; SUB 0x00-0x01 -> result=0xFF, zero=0, neg=1.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared types and defaults for the pico ALU: opcodes, FSM states and the
// multiply-op classifier.
package pico_pkg;

    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MUL  = 3'd5,
        OP_MULH = 3'd6,
        OP_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        WB      = 2'd2
    } alu_state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/pico_mul_seq.sv
// Sequential shift-add unsigned multiplier: one step per cycle for BUS_WIDTH
// cycles. done flags the final step; product then shows the finished value.
module pico_mul_seq #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   mcand,
    input  logic [BUS_WIDTH-1:0]   mplier,
    output logic                   done,
    output logic [2*BUS_WIDTH-1:0] product
);

    localparam int CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

    logic [2*BUS_WIDTH-1:0] acc_r;
    logic [2*BUS_WIDTH-1:0] acc_next_s;
    logic [BUS_WIDTH-1:0]   mcand_r;
    logic [BUS_WIDTH:0]     sum_s;
    logic [CW-1:0]          cnt_r;
    logic                   run_r;

    // One shift-add step: conditionally add multiplicand to the high half, shift right.
    always_comb begin
        sum_s      = {1'b0, acc_r[2*BUS_WIDTH-1:BUS_WIDTH]};
        if (acc_r[0]) begin
            sum_s = sum_s + {1'b0, mcand_r};
        end else begin
            sum_s = sum_s;
        end
        acc_next_s = {sum_s, acc_r[BUS_WIDTH-1:1]};
    end

    assign done    = run_r && (cnt_r == {CW{1'b0}});
    assign product = acc_next_s;

    // Accumulator, multiplicand and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= {(2*BUS_WIDTH){1'b0}};
            mcand_r <= {BUS_WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            run_r   <= 1'b0;
        end else if (start) begin
            acc_r   <= {{BUS_WIDTH{1'b0}}, mplier};
            mcand_r <= mcand;
            cnt_r   <= CW'(BUS_WIDTH - 1);
            run_r   <= 1'b1;
        end else if (run_r) begin
            acc_r <= acc_next_s;
            if (cnt_r == {CW{1'b0}}) begin
                run_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/pico_alu.sv
// Pico ALU: single-cycle logic/arith ops plus sequential MUL/MULH, with a
// register-file write port. Optional flag outputs under PICO_ALU_FLAGS_EN.
module pico_alu
    import pico_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [BUS_WIDTH-1:0]  a,
    input  logic [BUS_WIDTH-1:0]  b,
    input  logic [BUS_WIDTH-1:0]  imm,
    input  logic                  use_imm,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BUS_WIDTH-1:0]  result
`ifdef PICO_ALU_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  neg
`endif
);

    alu_state_t             state_r, state_next_s;
    alu_op_t                op_s, op_r;
    logic [BUS_WIDTH-1:0]   b_sel_s, alu_s, res_next_s, result_r;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_next_s, wr_addr_r;
    logic                   accept_s, mul_start_s, mul_done_s, load_s;
    logic [2*BUS_WIDTH-1:0] mul_prod_s;

    assign op_s        = alu_op_t'(op);
    assign b_sel_s     = use_imm ? imm : b;
    assign accept_s    = (state_r == IDLE) && start;
    assign mul_start_s = accept_s && is_mul_op(op_s);

    pico_mul_seq #(.BUS_WIDTH(BUS_WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .mcand   (a),
        .mplier  (b_sel_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Single-cycle operations.
    always_comb begin
        alu_s = {BUS_WIDTH{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = a + b_sel_s;
            OP_SUB:  alu_s = a - b_sel_s;
            OP_AND:  alu_s = a & b_sel_s;
            OP_OR:   alu_s = a | b_sel_s;
            OP_XOR:  alu_s = a ^ b_sel_s;
            OP_PASS: alu_s = b_sel_s;
            default: alu_s = {BUS_WIDTH{1'b0}};
        endcase
    end

    // Writeback value selection; loads only on entry to WB.
    always_comb begin
        load_s      = 1'b0;
        res_next_s  = result_r;
        addr_next_s = wr_addr_r;
        if (accept_s && !is_mul_op(op_s)) begin
            load_s      = 1'b1;
            res_next_s  = alu_s;
            addr_next_s = dest_addr;
        end else if ((state_r == MUL_RUN) && mul_done_s) begin
            load_s      = 1'b1;
            res_next_s  = (op_r == OP_MULH) ? mul_prod_s[2*BUS_WIDTH-1:BUS_WIDTH]
                                            : mul_prod_s[BUS_WIDTH-1:0];
            addr_next_s = addr_r;
        end else begin
            load_s      = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = is_mul_op(op_s) ? MUL_RUN : WB;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL_RUN: begin
                if (mul_done_s) begin
                    state_next_s = WB;
                end else begin
                    state_next_s = MUL_RUN;
                end
            end
            WB:      state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Captured request fields and held writeback registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r      <= OP_ADD;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            result_r  <= {BUS_WIDTH{1'b0}};
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                op_r   <= op_s;
                addr_r <= dest_addr;
            end
            if (load_s) begin
                result_r  <= res_next_s;
                wr_addr_r <= addr_next_s;
            end
        end
    end

`ifdef PICO_ALU_FLAGS_EN
    logic zero_r, neg_r;

    // Flags track the value loaded into result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load_s) begin
            zero_r <= (res_next_s == {BUS_WIDTH{1'b0}});
            neg_r  <= res_next_s[BUS_WIDTH-1];
        end else begin
            zero_r <= zero_r;
        end
    end

    assign zero = zero_r;
    assign neg  = neg_r;
`endif

    assign busy    = (state_r != IDLE);
    assign done    = (state_r == WB);
    assign we      = (state_r == WB);
    assign wr_addr = wr_addr_r;
    assign result  = result_r;

endmodule

// File: tb/tb_pico_alu.sv
// Directed self-checking bench for pico_alu (BUS_WIDTH=8, ADDR_WIDTH=5).
// Flag checks are included when PICO_ALU_FLAGS_EN is defined.
module tb_pico_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a, b, imm;
    logic       use_imm;
    logic [4:0] dest_addr;
    logic       busy, done, we;
    logic [4:0] wr_addr;
    logic [7:0] result;
`ifdef PICO_ALU_FLAGS_EN
    logic       zero, neg;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pico_alu #(.BUS_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .use_imm   (use_imm),
        .dest_addr (dest_addr),
        .busy      (busy),
        .done      (done),
        .we        (we),
        .wr_addr   (wr_addr),
        .result    (result)
`ifdef PICO_ALU_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] iv, input logic ui, input logic [4:0] d);
        op = o; a = av; b = bv; imm = iv; use_imm = ui; dest_addr = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Issue a multiply, check 8 busy non-done cycles, then the WB cycle.
    task automatic mul_run(input string tag, input logic [2:0] o, input logic [7:0] av,
                           input logic [7:0] bv, input logic [4:0] d,
                           input logic [7:0] expv, input bit poke);
        issue(o, av, bv, 8'h00, 1'b0, d);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_nodone"}, done, 1'b0);
            if (poke && i == 2) begin
                op = 3'd0; a = 8'h01; b = 8'h01; start = 1'b1;
            end
            if (poke && i == 5) start = 1'b0;
            step();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_we"}, we, 1'b1);
        check({tag, "_busy_wb"}, busy, 1'b1);
        check({tag, "_result"}, result, expv);
        check({tag, "_wr_addr"}, wr_addr, d);
        step();
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_hold"}, result, expv);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        imm = 8'h00; use_imm = 1'b0; dest_addr = 5'd0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_wr_addr", wr_addr, 5'd0);
        reset = 1'b0;
        step();

        // ADD wraps: F0 + 20 = 10
        issue(3'd0, 8'hF0, 8'h20, 8'h00, 1'b0, 5'd1);
        check("add_done", done, 1'b1);
        check("add_we", we, 1'b1);
        check("add_busy", busy, 1'b1);
        check("add_result", result, 8'h10);
        check("add_wr_addr", wr_addr, 5'd1);
        step();
        check("add_done_clr", done, 1'b0);
        check("add_busy_clr", busy, 1'b0);
        check("add_hold", result, 8'h10);

        // SUB with immediate: 05 - 07 = FE, b ignored
        issue(3'd1, 8'h05, 8'h99, 8'h07, 1'b1, 5'd3);
        check("sub_done", done, 1'b1);
        check("sub_result", result, 8'hFE);
        check("sub_wr_addr", wr_addr, 5'd3);
        step();
        check("sub_done_clr", done, 1'b0);

        // Other single-cycle ops
        issue(3'd2, 8'hCC, 8'hAA, 8'h00, 1'b0, 5'd4);
        check("and_result", result, 8'h88);
        step();
        issue(3'd3, 8'hC0, 8'h0A, 8'h00, 1'b0, 5'd4);
        check("or_result", result, 8'hCA);
        step();
        issue(3'd7, 8'h11, 8'h22, 8'h3C, 1'b1, 5'd4);
        check("pass_result", result, 8'h3C);
        step();

        // MUL 200*3 = 0x258 to dest 0 (we still asserted); start poked mid-run
        mul_run("mul", 3'd5, 8'd200, 8'd3, 5'd0, 8'h58, 1'b1);
        mul_run("mulh", 3'd6, 8'd200, 8'd3, 5'd2, 8'h02, 1'b0);

        // start held high: accepted every second cycle
        op = 3'd0; a = 8'h01; b = 8'h01; use_imm = 1'b0; dest_addr = 5'd5; start = 1'b1;
        step();
        check("b2b_done0", done, 1'b1);
        check("b2b_res0", result, 8'h02);
        a = 8'h02;
        step();
        check("b2b_done1", done, 1'b0);
        check("b2b_res1", result, 8'h02);
        a = 8'h03;
        step();
        check("b2b_done2", done, 1'b1);
        check("b2b_res2", result, 8'h04);
        start = 1'b0;
        step();
        check("b2b_done3", done, 1'b0);

        // Reset 4 cycles into MUL 13*11 aborts without a write pulse
        issue(3'd5, 8'd13, 8'd11, 8'h00, 1'b0, 5'd7);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_we", we, 1'b0);
        check("arst_result", result, 8'h00);
        check("arst_wr_addr", wr_addr, 5'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("arst_no_done", done, 1'b0);
            step();
        end
        mul_run("mul2", 3'd5, 8'd13, 8'd11, 5'd7, 8'h8F, 1'b0);

`ifdef PICO_ALU_FLAGS_EN
        issue(3'd4, 8'h5A, 8'h5A, 8'h00, 1'b0, 5'd1);
        check("xor_result", result, 8'h00);
        check("xor_zero", zero, 1'b1);
        check("xor_neg", neg, 1'b0);
        step();
        issue(3'd1, 8'h00, 8'h01, 8'h00, 1'b0, 5'd1);
        check("subn_result", result, 8'hFF);
        check("subn_zero", zero, 1'b0);
        check("subn_neg", neg, 1'b1);
        step();
        check("flag_hold", neg, 1'b1);
`else
        issue(3'd4, 8'h5A, 8'h0F, 8'h00, 1'b0, 5'd1);
        check("xor_result", result, 8'h55);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
